// File: rtl/dac_tx.sv
// dac_tx: sample FIFO feeding a parallel DAC at one sample per DIV clock cycles.
// A free-running phase counter (active while Enable=1) defines sample slots;
// each slot pops the FIFO head into the registered Dac_data word, or flags a
// sticky underrun when the FIFO is empty. Dac_clk is a registered half-duty
// latch clock aligned so that Dac_data settles DIV/2 cycles before each rise.
// Optional build macro: DAC_TX_OFFSET_BINARY_EN (two's complement in,
// offset binary out, reset word 12'h800).
module dac_tx #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     Fg_clk,
  input  logic                     Resetn,
  input  logic                     Enable,
  input  logic                     In_valid,
  input  logic [11:0]              In_data,
  output logic                     In_ready,
  input  logic                     Underrun_clr,
  output logic [11:0]              Dac_data,
  output logic                     Dac_clk,
  output logic                     Underrun,
  output logic [$clog2(DEPTH):0]   Level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(DIV);
  localparam logic [AW:0]   LVL_FULL   = (AW + 1)'(DEPTH);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PHASE_HIGH = PW'(DIV / 2);

`ifdef DAC_TX_OFFSET_BINARY_EN
  localparam logic [11:0] DATA_RST = 12'h800;
`else
  localparam logic [11:0] DATA_RST = 12'h000;
`endif

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] phase;
  logic          slot;
  logic          push;
  logic          pop;
  logic [11:0]   head_word;

  assign In_ready = (Level != LVL_FULL);
  assign slot     = Enable && (phase == '0);
  assign push     = In_valid && In_ready;
  assign pop      = slot && (Level != '0);

  // Output word formatting of the FIFO head
  always_comb begin
    head_word = mem[rd_ptr];
`ifdef DAC_TX_OFFSET_BINARY_EN
    head_word[11] = ~mem[rd_ptr][11];
`endif
  end

  // FIFO storage write port; contents deliberately not reset
  always_ff @(posedge Fg_clk) begin
    if (push) begin
      mem[wr_ptr] <= In_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   Level <= Level + 1'b1;
        2'b01:   Level <= Level - 1'b1;
        default: Level <= Level;
      endcase
    end
  end

  // Sample-period phase counter; disabling abandons the current period
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      phase <= '0;
    end else if (!Enable) begin
      phase <= '0;
    end else if (phase == PHASE_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  // Registered DAC word and latch clock, both one cycle behind the phase
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      Dac_data <= DATA_RST;
      Dac_clk  <= 1'b0;
    end else begin
      if (pop) Dac_data <= head_word;
      Dac_clk <= Enable && (phase >= PHASE_HIGH);
    end
  end

  // Sticky underrun; a set in the same cycle as a clear wins
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      Underrun <= 1'b0;
    end else if (slot && (Level == '0)) begin
      Underrun <= 1'b1;
    end else if (Underrun_clr) begin
      Underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_tx.sv
// tb_dac_tx: randomized scoreboard bench for dac_tx (DIV=4, DEPTH=8).
module tb_dac_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;

`ifdef DAC_TX_OFFSET_BINARY_EN
  localparam logic [11:0] RST_WORD = 12'h800;
  localparam logic [11:0] XFORM    = 12'h800;
`else
  localparam logic [11:0] RST_WORD = 12'h000;
  localparam logic [11:0] XFORM    = 12'h000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_ready;
  logic        und_clr = 1'b0;
  logic [11:0] dac_data;
  logic        dac_clk;
  logic        underrun;
  logic [3:0]  level;

  int n_checks = 0;
  int n_fail   = 0;

  dac_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .Fg_clk      (clk),
    .Resetn      (rst_n),
    .Enable      (en),
    .In_valid    (in_valid),
    .In_data     (in_data),
    .In_ready    (in_ready),
    .Underrun_clr(und_clr),
    .Dac_data    (dac_data),
    .Dac_clk     (dac_clk),
    .Underrun    (underrun),
    .Level       (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] m_fifo[$];
  logic [11:0] out_q[$];    // expected word at each Dac_clk rise
  logic [11:0] m_dac;
  logic        m_dclk;
  logic        m_und;
  int          en_cnt;      // consecutive enabled cycles since Enable rose
  logic        check_range = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete();
      out_q.delete();
      m_dac  = RST_WORD;
      m_dclk = 1'b0;
      m_und  = 1'b0;
      en_cnt = 0;
    end else begin
      int  ph;
      bit  full;
      bit  und_set;
      ph      = en_cnt % DIV;
      full    = (m_fifo.size() == DEPTH);
      und_set = 1'b0;
      if (en && ph == 0) begin
        if (m_fifo.size() > 0) m_dac = m_fifo.pop_front() ^ XFORM;
        else                   und_set = 1'b1;
      end
      if (in_valid && !full) m_fifo.push_back(in_data);
      if (und_set)      m_und = 1'b1;
      else if (und_clr) m_und = 1'b0;
      m_dclk = en && (ph >= DIV / 2);
      if (en && ph == DIV / 2) out_q.push_back(m_dac);
      en_cnt = en ? en_cnt + 1 : 0;
    end
  end

  // Per-cycle state comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("dac_data", int'(dac_data), int'(m_dac));
      chk("dac_clk", int'(dac_clk), int'(m_dclk));
      chk("underrun", int'(underrun), int'(m_und));
      chk("level", int'(level), m_fifo.size());
      chk("in_ready", int'(in_ready), int'(m_fifo.size() != DEPTH));
      if (check_range) chk("level_7_8", int'(level >= 7 && level <= 8), 1);
    end
  end

  // Scoreboard monitor: each Dac_clk rise presents a word to the DAC
  logic prev_dclk = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dclk <= 1'b0;
    end else begin
      if (dac_clk && !prev_dclk) begin
        if (out_q.size() == 0) begin
          chk("unexpected_dac_rise", 1, 0);
        end else begin
          logic [11:0] e;
          e = out_q.pop_front();
          chk("dac_word_at_rise", int'(dac_data), int'(e));
        end
      end
      prev_dclk <= dac_clk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic e, input logic v, input logic [11:0] d, input logic c);
    en = e; in_valid = v; in_data = d; und_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_dac_data", int'(dac_data), int'(RST_WORD));
    chk("rst_dac_clk", int'(dac_clk), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    en = 1'b0; in_valid = 1'b0; und_clr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    do_reset();

    // Enabled with nothing queued: clock toggles, word holds, underrun sets
    for (int i = 0; i < 12; i++) step(1, 0, '0, 0);

    // Three ordered samples
    do_reset();
    step(0, 1, 12'h123, 0);
    step(0, 1, 12'h456, 0);
    step(0, 1, 12'h789, 0);
    for (int i = 0; i < 16; i++) step(1, 0, '0, 0);
    chk("three_drained_level", int'(level), 0);

    // Fill while disabled; ninth sample must be refused
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, 12'(12'hA00 + i), 0);
    chk("full_level", int'(level), DEPTH);
    chk("full_in_ready", int'(in_ready), 0);

    // Full FIFO streaming with In_valid held high
    check_range = 1'b1;
    for (int i = 0; i < 40; i++) step(1, 1, 12'($urandom), 0);
    check_range = 1'b0;
    for (int i = 0; i < 40; i++) step(1, 0, '0, (i == 30));

    // Enable dropped at phase 2, raised 5 cycles later
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 12'($urandom), 0);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, 0);
      chk("disabled_dac_clk", int'(dac_clk), 0);
    end
    step(1, 0, '0, 0);
    chk("reenable_pop_level", int'(level), 2);
    for (int i = 0; i < 12; i++) step(1, 0, '0, 0);

    // Offset-binary conversion of an all-ones sample
    do_reset();
    step(0, 1, 12'hFFF, 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0);
`ifdef DAC_TX_OFFSET_BINARY_EN
    chk("offset_fff", int'(dac_data), 12'h7FF);
`else
    chk("plain_fff", int'(dac_data), 12'hFFF);
`endif

    // Randomized traffic: varied push density, enable gaps, clears
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic e, v, c;
      e = ($urandom_range(0, 9) != 0);
      v = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      step(e, v, 12'($urandom), c);
    end

    // Reset mid-period with samples queued
    step(1, 1, 12'h5A5, 0);
    step(1, 1, 12'h3C3, 0);
    do_reset();
    chk("post_reset_level", int'(level), 0);
    for (int i = 0; i < 8; i++) step(1, 0, '0, 0);

    // Drain and confirm every expected DAC word was presented
    for (int i = 0; i < 8; i++) step(1, 0, '0, 0);
    chk("scoreboard_empty", out_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_tx.md
DAC_TX -- requirements
Module: dac_tx

Interface
REQ-001 Parameter DIV, default 4: Fg_clk cycles per DAC sample period; even, >= 2.
REQ-002 Parameter DEPTH, default 8: sample FIFO depth; power of two, >= 2.
REQ-003 Fg_clk  input  1  single clock for all logic; rising-edge triggered.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 Enable  input  1  output streaming enable, from sampling control.
REQ-006 In_valid  input  1  In_data holds a valid sample.
REQ-007 In_data  input  12  sample from the interpolator.
REQ-008 In_ready  output  1  FIFO can accept a sample this cycle.
REQ-009 Underrun_clr  input  1  clears the sticky Underrun flag.
REQ-010 Dac_data  output  12  parallel DAC data word, registered.
REQ-011 Dac_clk  output  1  DAC latch clock, registered.
REQ-012 Underrun  output  1  sticky flag: a sample slot found the FIFO empty.
REQ-013 Level  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A push occurs on a cycle with In_valid=1 and In_ready=1.
REQ-015 In_ready = (Level != DEPTH), driven from registered state.
REQ-016 A push while full is impossible; In_data is ignored when In_ready=0.
REQ-017 The phase counter counts 0..DIV-1 and wraps while Enable=1.
REQ-018 Each phase-0 cycle with Enable=1 is a sample slot.
REQ-019 At a slot with Level>0: pop the FIFO head; Dac_data takes the head on the next edge.
REQ-020 At a slot with Level=0: Dac_data holds its value; Underrun is set on the next edge.
REQ-021 Dac_clk = 0 for phases 0..DIV/2-1 and 1 for phases DIV/2..DIV-1, registered (one-cycle delay matching Dac_data).
REQ-022 Dac_data is stable for DIV/2 cycles before each Dac_clk rising edge.
REQ-023 Push and pop in the same cycle: Level is unchanged and FIFO order is preserved.
REQ-024 Push into an empty FIFO on a slot cycle: no bypass; the slot underruns; the sample is output at the next slot.
REQ-025 Enable=0: phase is forced to 0; Dac_clk is 0 from the next edge; Dac_data holds; no pops occur; pushes are still accepted.
REQ-026 Enable falls mid-period: the period is abandoned; when Enable rises again, the first cycle with Enable=1 is a slot.
REQ-027 Underrun_clr=1 clears Underrun on the next edge. A simultaneous set takes priority, so Underrun stays 1.
REQ-028 Read and write pointers wrap modulo DEPTH; Level saturates at neither end, by construction.

Reset
REQ-029 Resetn=0 immediately sets: Dac_data=0, Dac_clk=0, Underrun=0, Level=0, phase=0, both pointers=0.
REQ-030 In_ready=1 while in reset and after reset.
REQ-031 FIFO storage contents are not reset.
REQ-032 Reset asserted mid-period aborts the period and discards all queued samples.

Configuration
REQ-033 Macro DAC_TX_OFFSET_BINARY_EN, when defined: In_data is treated as two's complement, and Dac_data is the popped sample with bit 11 inverted (offset binary); the reset value of Dac_data becomes 12'h800.
REQ-034 When DAC_TX_OFFSET_BINARY_EN is undefined: Dac_data is the popped sample unmodified, and its reset value is 0.

Verification
REQ-035 Reset, then Enable=1 with no pushes, DIV=4 -> Dac_clk toggles 0,0,1,1; Dac_data=0; Underrun=1 after the first slot.
REQ-036 Push 12'h123, 12'h456, 12'h789, then Enable=1 -> Dac_data shows them in order, each stable 4 cycles; each changes 2 cycles before a Dac_clk rise; Level returns to 0.
REQ-037 Push continuously with Enable=0 -> In_ready drops after 8 accepted pushes; Level=8; the 9th sample is not stored.
REQ-038 Full FIFO, Enable=1, In_valid held high -> pushes resume one cycle after each pop; Level stays in the range 7..8; no sample lost or duplicated.
REQ-039 Drop Enable at phase 2, raise it 5 cycles later -> Dac_clk=0 while disabled; the first enabled cycle pops.
REQ-040 With DAC_TX_OFFSET_BINARY_EN defined, push 12'hFFF -> Dac_data=12'h7FF; Dac_data=12'h800 after reset.
